// File: rtl/press_counter_pkg.sv
// Shared helpers for the push-button event counter: seven-segment glyphs,
// ceil(log2) and the history ring index width.
package press_counter_pkg;

  // Active-low glyphs for 0-F, bit0 = segment a; entry n is the glyph of nibble n.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_GLYPHS[nib];
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Ring pointers need at least one bit even for degenerate depths.
  function automatic int ring_idx_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/press_counter_ext_if.sv
// Signal bundle between the board (keys, switches, LEDs, display) and the counter.
// evt_o is a one-cycle strobe with no ready: a consumer must sample it in the cycle it is high.
interface press_counter_ext_if
  import press_counter_pkg::*;
#(
  parameter int SW_W       = 10,
  parameter int CNT_W      = 8,
  parameter int HIST_DEPTH = 4
) ();
  localparam int IDX_W  = ring_idx_w(HIST_DEPTH);
  localparam int DIGITS = (CNT_W + 3) / 4;

  logic                  btn_up_ni;
  logic                  btn_dn_ni;
  logic                  clr_i;
  logic [SW_W-1:0]       sw_i;
  logic [IDX_W-1:0]      hist_sel_i;
  logic [SW_W-1:0]       ledr_o;
  logic [CNT_W-1:0]      count_o;
  logic [7*DIGITS-1:0]   hex_o;
  logic                  evt_o;
  logic                  ovf_o;
  logic [IDX_W:0]        hist_cnt_o;
  logic [1:0]            key_lvl_o;   // debug: debounced pressed levels {dn, up}

  modport slave (
    input  btn_up_ni, btn_dn_ni, clr_i, sw_i, hist_sel_i,
    output ledr_o, count_o, hex_o, evt_o, ovf_o, hist_cnt_o, key_lvl_o
  );

  modport master (
    output btn_up_ni, btn_dn_ni, clr_i, sw_i, hist_sel_i,
    input  ledr_o, count_o, hex_o, evt_o, ovf_o, hist_cnt_o, key_lvl_o
  );
endinterface

// File: rtl/press_counter_ext_debounce.sv
// One key: 2-flop synchroniser, stable-count debouncer and a one-cycle press pulse
// registered the cycle after the debounced level goes released->pressed.
module btn_debounce
  import press_counter_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_o
);
  localparam int CW = clog2(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          stable_d_q;
  logic          level;

  assign level     = ~sync_q[1];
  assign pressed_o = stable_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
      press_o    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], key_ni};
      stable_d_q <= stable_q;
      press_o    <= stable_q & ~stable_d_q;
      // The DEB_CYCLES-th consecutive differing sample flips the stable level.
      if (level != stable_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          stable_q <= level;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/press_counter_ext.sv
// Up/down press counter with a switch-word history ring and seven-segment display of the count.
module press_counter_ext
  import press_counter_pkg::*;
#(
  parameter int SW_W       = 10,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 1000000,
  parameter int HIST_DEPTH = 4,
  parameter int SATURATE   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  press_counter_ext_if.slave  bus
);
  localparam int IDX_W  = ring_idx_w(HIST_DEPTH);
  localparam int HC_W   = IDX_W + 1;
  localparam int DIGITS = (CNT_W + 3) / 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic up_p, dn_p, up_lvl, dn_lvl;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_i(clk_i), .rst_i(rst_i), .key_ni(bus.btn_up_ni),
    .pressed_o(up_lvl), .press_o(up_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk_i(clk_i), .rst_i(rst_i), .key_ni(bus.btn_dn_ni),
    .pressed_o(dn_lvl), .press_o(dn_p)
  );

  logic [CNT_W-1:0] count_q, count_nx;
  logic             ovf_q, evt_q;
  logic             up_ev, dn_ev, ev, edge_hit;
  logic [SW_W-1:0]  ring_q [HIST_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, rd_idx;
  logic [HC_W-1:0]  hist_cnt_q;

  // Simultaneous pulses cancel: neither direction is taken.
  assign up_ev = up_p & ~dn_p;
  assign dn_ev = dn_p & ~up_p;
  assign ev    = up_ev | dn_ev;

  always_comb begin
    count_nx = count_q;
    edge_hit = (up_ev && count_q == CNT_MAX) || (dn_ev && count_q == '0);
    if (up_ev)      count_nx = count_q + 1'b1;
    else if (dn_ev) count_nx = count_q - 1'b1;
    if (SATURATE != 0 && edge_hit) count_nx = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clr_i) begin
      count_q    <= '0;
      ovf_q      <= 1'b0;
      evt_q      <= 1'b0;
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      evt_q <= ev;
      if (ev) begin
        count_q          <= count_nx;
        ovf_q            <= ovf_q | edge_hit;
        ring_q[wr_ptr_q] <= bus.sw_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        if (hist_cnt_q != HC_W'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + 1'b1;
      end
    end
  end

  // Newest entry sits just behind the write pointer; unwritten slots read as zero.
  assign rd_idx      = wr_ptr_q - IDX_W'(1) - bus.hist_sel_i;
  assign bus.ledr_o  = (HC_W'(bus.hist_sel_i) < hist_cnt_q) ? ring_q[rd_idx] : '0;

  assign bus.count_o    = count_q;
  assign bus.evt_o      = evt_q;
  assign bus.ovf_o      = ovf_q;
  assign bus.hist_cnt_o = hist_cnt_q;
  assign bus.key_lvl_o  = {dn_lvl, up_lvl};

  logic [4*DIGITS-1:0] cnt_pad;
  assign cnt_pad = (4*DIGITS)'(count_q);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign bus.hex_o[7*k +: 7] = seg_decode(cnt_pad[4*k +: 4]);
  end
endmodule
